// File: rtl/matrix_store_writer.sv
// Result-matrix sink: writes three metadata words, then streams rows*cols data
// words into the BRAM slot selected by matrix_id, and pulses write_done at the end.
module matrix_store_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int BLOCK_SIZE = 256,
    parameter int META_WORDS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_request,
    output logic                  write_ready,
    input  logic [2:0]            matrix_id,
    input  logic [7:0]            actual_rows,
    input  logic [7:0]            actual_cols,
    input  logic [7:0]            matrix_name [0:7],
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  writer_ready,
    output logic                  write_done,
    output logic                  write_err,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic [2:0]            dbg_state_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_META0  = 3'd1;
    localparam logic [2:0] S_META1  = 3'd2;
    localparam logic [2:0] S_META2  = 3'd3;
    localparam logic [2:0] S_STREAM = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [31:0] CAPACITY = 32'(BLOCK_SIZE - META_WORDS);

    logic [2:0]            state_q, state_d;
    logic [15:0]           idx_q, idx_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [7:0]            rows_q, cols_q;
    logic [15:0]           n_q;
    logic [7:0]            name_q [0:7];

    logic                  accept;
    logic [15:0]           n_req;

    assign accept = (state_q == S_IDLE) && write_request;
    assign n_req  = 16'(actual_rows) * 16'(actual_cols);

    // Handshakes: a request is taken on any edge where write_request && write_ready;
    // a data word is taken on any edge where data_valid && writer_ready. Outside
    // those windows both inputs are ignored, and neither ready depends on a valid.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (write_request) begin
                    idx_d = '0;
                    if (32'(n_req) > CAPACITY) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_META0;
                    end
                end
            end
            S_META0: state_d = S_META1;
            S_META1: state_d = S_META2;
            S_META2: state_d = (n_q == 16'd0) ? S_DONE : S_STREAM;
            S_STREAM: begin
                if (data_valid) begin
                    idx_d = idx_q + 16'd1;
                    if (idx_q + 16'd1 == n_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Transaction payload is captured once at accept and held for the whole block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            rows_q <= '0;
            cols_q <= '0;
            n_q    <= '0;
            for (int i = 0; i < 8; i++) name_q[i] <= '0;
        end else if (accept) begin
            base_q <= ADDR_WIDTH'(32'(matrix_id) * 32'(BLOCK_SIZE));
            rows_q <= actual_rows;
            cols_q <= actual_cols;
            n_q    <= n_req;
            for (int i = 0; i < 8; i++) name_q[i] <= matrix_name[i];
        end
    end

    assign write_ready  = (state_q == S_IDLE);
    assign writer_ready = (state_q == S_STREAM);
    assign write_done   = (state_q == S_DONE);
    assign write_err    = (state_q == S_DONE) && err_q;
    assign dbg_state_o  = state_q;

    // idx stays below n <= BLOCK_SIZE-META_WORDS, so the address never leaves the slot.
    always_comb begin
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        case (state_q)
            S_META0: begin
                bram_we   = 1'b1;
                bram_addr = base_q;
                bram_din  = DATA_WIDTH'({rows_q, cols_q, 16'h0000});
            end
            S_META1: begin
                bram_we   = 1'b1;
                bram_addr = base_q + ADDR_WIDTH'(1);
                bram_din  = DATA_WIDTH'({name_q[0], name_q[1], name_q[2], name_q[3]});
            end
            S_META2: begin
                bram_we   = 1'b1;
                bram_addr = base_q + ADDR_WIDTH'(2);
                bram_din  = DATA_WIDTH'({name_q[4], name_q[5], name_q[6], name_q[7]});
            end
            S_STREAM: begin
                bram_we   = data_valid;
                bram_addr = base_q + ADDR_WIDTH'(META_WORDS) + ADDR_WIDTH'(idx_q);
                bram_din  = data_in;
            end
            default: begin
                bram_we   = 1'b0;
                bram_addr = '0;
                bram_din  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_matrix_store_writer.sv
// Bench for matrix_store_writer: table of transactions plus hand sequences for
// stray inputs and mid-stream reset, with every BRAM write checked against a queue.
module tb_matrix_store_writer;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int BS = 256;

  logic          clk;
  logic          rst_n;
  logic          write_request;
  logic          write_ready;
  logic [2:0]    matrix_id;
  logic [7:0]    actual_rows;
  logic [7:0]    actual_cols;
  logic [7:0]    name_arr [0:7];
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          writer_ready;
  logic          write_done;
  logic          write_err;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [2:0]    dbg_state;

  matrix_store_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .META_WORDS(3)) dut (
    .clk(clk), .rst_n(rst_n), .write_request(write_request), .write_ready(write_ready),
    .matrix_id(matrix_id), .actual_rows(actual_rows), .actual_cols(actual_cols),
    .matrix_name(name_arr), .data_in(data_in), .data_valid(data_valid),
    .writer_ready(writer_ready), .write_done(write_done), .write_err(write_err),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int we_count = 0;
  int done_cnt = 0;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW+DW-1:0] exp_q[$];

  typedef struct {
    logic [2:0]  id;
    logic [7:0]  rows;
    logic [7:0]  cols;
    logic [63:0] name;
    logic [31:0] dstart;
    bit          toggle;
    bit          poke;
    int          exp_lat;
    bit          exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // scoreboard: every BRAM write must match the head of the expected queue
  always @(negedge clk) begin
    if (write_done) done_cnt++;
    if (bram_we) begin
      we_count++;
      mem[bram_addr] = bram_din;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", bram_addr, bram_din);
      end else begin
        chk("bram_write", 64'({bram_addr, bram_din}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic push(input int addr, input logic [31:0] data);
    logic [AW-1:0] a;
    a = AW'(addr);
    exp_q.push_back({a, data});
  endtask

  task automatic set_name(input logic [63:0] nm);
    for (int i = 0; i < 8; i++) name_arr[i] = nm[63-8*i -: 8];
  endtask

  task automatic push_meta(input vec_t v);
    int base;
    base = int'(v.id) * BS;
    push(base, {v.rows, v.cols, 16'h0000});
    push(base + 1, v.name[63:32]);
    push(base + 2, v.name[31:0]);
  endtask

  // driver: one full transaction, latency counted from the accept edge
  task automatic run_txn(input vec_t v, input string tag);
    int c, s, cnt, k, n, base, we0;
    bit seen;
    @(posedge clk); #1;
    k = 0;
    while (!write_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    n = int'(v.rows) * int'(v.cols);
    base = int'(v.id) * BS;
    we0 = we_count;
    if (!v.exp_err) begin
      push_meta(v);
      for (int i = 0; i < n; i++) push(base + 3 + i, v.dstart + 32'(i));
    end
    matrix_id = v.id;
    actual_rows = v.rows;
    actual_cols = v.cols;
    set_name(v.name);
    write_request = 1'b1;
    data_valid = !v.toggle;
    data_in = 32'hDEAD0000;
    c = 0; s = 0; cnt = 0; seen = 0;
    while (!seen && c < 400) begin
      @(posedge clk); #1;
      c++;
      write_request = v.poke && (c == 5);
      matrix_id = (v.poke && c == 5) ? ~v.id : v.id;
      actual_rows = (v.poke && c == 5) ? 8'd1 : v.rows;
      if (writer_ready) begin
        data_valid = v.toggle ? (s % 2 == 0) : 1'b1;
        s++;
        if (data_valid) begin
          data_in = v.dstart + 32'(cnt);
          cnt++;
        end else begin
          data_in = 32'hBAD00000 + 32'(c);
        end
      end else begin
        data_valid = !v.toggle;
        data_in = 32'hDEAD0000 + 32'(c);
      end
      @(negedge clk);
      if (write_done) begin
        seen = 1;
        chk({tag, "_latency"}, 64'(c), 64'(v.exp_lat));
        chk({tag, "_err"}, 64'(write_err), 64'(v.exp_err));
        chk({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_we_cycles"}, 64'(we_count - we0), 64'(v.exp_err ? 0 : n + 3));
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no write_done after %0d cycles, want cycle %0d", tag, c, v.exp_lat);
      exp_q.delete();
    end
    write_request = 1'b0;
    data_valid = 1'b0;
  endtask

  initial begin
    vec_t rv;
    int we0, d0, cnt;

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rst_n = 1'b0;
    write_request = 1'b0;
    matrix_id = '0;
    actual_rows = '0;
    actual_cols = '0;
    set_name(64'h0);
    data_in = '0;
    data_valid = 1'b0;

    vecs[0] = '{3'd1, 8'd2,   8'd3,   64'h5453520000000000, 32'd1,    1'b0, 1'b0, 10,  1'b0};
    vecs[1] = '{3'd0, 8'd3,   8'd1,   64'h4D41545249580000, 32'd7,    1'b1, 1'b0, 9,   1'b0};
    vecs[2] = '{3'd3, 8'd0,   8'd5,   64'h5A45524F00000000, 32'd50,   1'b0, 1'b0, 4,   1'b0};
    vecs[3] = '{3'd4, 8'd255, 8'd255, 64'h4249470000000000, 32'd0,    1'b0, 1'b0, 1,   1'b1};
    vecs[4] = '{3'd5, 8'd4,   8'd4,   64'h504F4B4500000000, 32'd100,  1'b0, 1'b1, 20,  1'b0};
    vecs[5] = '{3'd7, 8'd11,  8'd23,  64'h46554C4C534C4F54, 32'd1000, 1'b0, 1'b0, 257, 1'b0};
    vecs[6] = '{3'd6, 8'd1,   8'd254, 64'h4F56455200000000, 32'd0,    1'b0, 1'b0, 1,   1'b1};
    vecs[7] = '{3'd2, 8'd1,   8'd1,   64'h4F4E450000000000, 32'd42,   1'b1, 1'b0, 5,   1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_write_ready", 64'(write_ready), 64'd1);
    chk("rst_writer_ready", 64'(writer_ready), 64'd0);
    chk("rst_done_err", 64'({write_done, write_err}), 64'd0);
    chk("rst_bram", 64'({bram_we, bram_addr, bram_din}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        chk("mem_meta0", 64'(mem[BS]), 64'h02030000);
        chk("mem_meta1", 64'(mem[BS + 1]), 64'h54535200);
        chk("mem_data_last", 64'(mem[BS + 8]), 64'd6);
      end
      if (i == 1) begin
        chk("mem_id0_w0", 64'(mem[3]), 64'd7);
        chk("mem_id0_w2", 64'(mem[5]), 64'd9);
      end
      if (i == 2) chk("mem_zero_rows_meta", 64'(mem[3 * BS]), 64'h00050000);
    end

    // data_valid while idle must not write or disturb the FSM
    @(posedge clk); #1;
    we0 = we_count;
    d0 = done_cnt;
    data_valid = 1'b1;
    data_in = 32'hFFFF0001;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("idle_valid_no_we", 64'(we_count - we0), 64'd0);
    chk("idle_valid_ready", 64'(write_ready), 64'd1);
    chk("idle_valid_no_done", 64'(done_cnt - d0), 64'd0);
    @(posedge clk); #1;
    data_valid = 1'b0;

    // reset after two data words of a 2x3 stream
    rv = '{3'd2, 8'd2, 8'd3, 64'h5253540000000000, 32'd20, 1'b0, 1'b0, 10, 1'b0};
    push_meta(rv);
    push(2 * BS + 3, 32'd20);
    push(2 * BS + 4, 32'd21);
    matrix_id = rv.id;
    actual_rows = rv.rows;
    actual_cols = rv.cols;
    set_name(rv.name);
    write_request = 1'b1;
    data_valid = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      write_request = 1'b0;
      if (c == 6) begin
        rst_n = 1'b0;
      end else if (writer_ready) begin
        data_in = 32'd20 + 32'(cnt);
        cnt++;
      end
    end
    d0 = done_cnt;
    @(negedge clk);
    chk("midrst_write_ready", 64'(write_ready), 64'd1);
    chk("midrst_writer_ready", 64'(writer_ready), 64'd0);
    chk("midrst_outputs", 64'({write_done, write_err, bram_we, bram_addr, bram_din}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    data_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("midrst_queue", 64'(exp_q.size()), 64'd0);
    chk("midrst_word2_kept", 64'(mem[2 * BS + 4]), 64'd21);
    chk("midrst_word3_absent", 64'(mem[2 * BS + 5]), 64'd0);
    rv.dstart = 32'd30;
    run_txn(rv, "after_rst");
    chk("after_rst_word3", 64'(mem[2 * BS + 5]), 64'd32);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
